pc_gen: RTL

Parametrised program-counter generator for the RV32I cores. It replaces the single enable-gated PC register with a full next-PC unit that handles boot sequencing, stalls, branch/jump redirects, trap entry, halt/resume and misaligned-target detection. It also provides an optional return-address-stack predictor. It sits at the head of the fetch stage, drives the instruction-memory address, and takes redirects from execute and traps from the CSR/exception logic.

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_ras.sv | 51 +++++
 rtl/pc_gen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
// States, the fetch increment and the instruction-alignment mask.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_BOOT,
        PC_RUN,
        PC_HALT
    } pc_state_e;

    localparam int unsigned PC_INC = 4;

    // Without the C extension every fetch target must be word aligned.
    localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop when empty is ignored, push+pop together replaces the top entry.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            nrst_i,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_pc,
    output logic            valid,
    output logic [XLEN-1:0] top_pc
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]   top;
    logic [CW-1:0]   count;
    logic [PW-1:0]   top_up;

    assign top_up = top + PW'(1);

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack[i] <= '0;
            end
            top   <= '0;
            count <= '0;
        end else if (push && pop && count != '0) begin
            stack[top] <= push_pc;
        end else if (push) begin
            // Pointer wraps naturally because RAS_DEPTH is a power of two.
            top           <= top_up;
            stack[top_up] <= push_pc;
            if (count != CW'(RAS_DEPTH)) begin
                count <= count + CW'(1);
            end
        end else if (pop && count != '0) begin
            top   <= top - PW'(1);
            count <= count - CW'(1);
        end
    end

    assign valid  = (count != '0);
    assign top_pc = valid ? stack[top] : '0;

endmodule

// File: rtl/pc_gen.sv
// Next-PC unit at the head of fetch: boot, stall, redirect, trap, halt and
// misaligned-target handling. Optional return-address stack under PC_RAS_EN.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            nrst_i,
    input  logic            stall_i,
    input  logic            halt_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_next_o,
    output logic            fetch_valid_o,
    output logic            misaligned_o,
    output logic            ras_valid_o,
    output logic [XLEN-1:0] ras_pc_o
);

    pc_state_e       state, state_next;
    logic [XLEN-1:0] pc_q, pc_next;
    logic            mis_q, mis_next;
    logic            target_misaligned;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_inc;

    // A misaligned redirect becomes a trap entry instead of a silent truncation.
    assign target_misaligned = (redirect_pc_i[1:0] & PC_ALIGN_MASK) != 2'b00;
    assign redirect_target   = target_misaligned ? trap_vec_i : redirect_pc_i;
    assign pc_inc            = pc_q + XLEN'(PC_INC);

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        mis_next   = 1'b0;
        case (state)
            PC_BOOT: begin
                state_next = PC_RUN;
            end
            PC_RUN: begin
                if (trap_i) begin
                    pc_next = trap_vec_i;
                end else if (redirect_valid_i) begin
                    pc_next  = redirect_target;
                    mis_next = target_misaligned;
                end else if (halt_i) begin
                    state_next = PC_HALT;
                end else if (!stall_i) begin
                    pc_next = pc_inc;
                end
            end
            PC_HALT: begin
                if (trap_i) begin
                    pc_next    = trap_vec_i;
                    state_next = PC_RUN;
                end else if (redirect_valid_i) begin
                    pc_next    = redirect_target;
                    mis_next   = target_misaligned;
                    state_next = PC_RUN;
                end
            end
            default: begin
                state_next = PC_BOOT;
                pc_next    = RESET_VEC;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state <= PC_BOOT;
            pc_q  <= RESET_VEC;
            mis_q <= 1'b0;
        end else begin
            state <= state_next;
            pc_q  <= pc_next;
            mis_q <= mis_next;
        end
    end

    assign pc_o          = pc_q;
    assign pc_next_o     = pc_next;
    assign fetch_valid_o = (state == PC_RUN);
    assign misaligned_o  = mis_q;

`ifdef PC_RAS_EN
    logic ras_push, ras_pop;

    // Call/return hints only count while fetching and not back-pressured.
    assign ras_push = (state == PC_RUN) && !stall_i && call_i;
    assign ras_pop  = (state == PC_RUN) && !stall_i && ret_i;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .push    (ras_push),
        .pop     (ras_pop),
        .push_pc (pc_inc),
        .valid   (ras_valid_o),
        .top_pc  (ras_pc_o)
    );
`else
    logic ras_unused;

    assign ras_unused  = call_i ^ ret_i;
    assign ras_valid_o = 1'b0;
    assign ras_pc_o    = '0;
`endif

endmodule
